inst_loader: RTL and testbench
==============================

# inst_loader

Program loader for the processor's writable instruction memory: the write side of instruction fetch. It accepts a stream of machine-code words over a valid/ready handshake and writes them to consecutive instruction addresses starting at 0. It then optionally pads the rest of memory with a fill word. The core is held in reset (`CpuHold`) until the image is complete. Sits between the testbench or host link and the dual-port instruction RAM's write port.

## Interface
- `IW`, 10, program-counter width; memory depth is 2**IW words.
- `DW`, 9, machine-code word width.
- `FILL_EN`, 1, when 1, addresses after the last loaded word are written with `FILL_WORD`.
- `FILL_WORD`, all-ones (`{DW{1'b1}}`), pad value (halt encoding).

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Start`  in  1  begin a load; sampled only in IDLE, DONE, ERR.
- `InValid`  in  1  `InData` / `InLast` valid.
- `InData`  in  DW  instruction word.
- `InLast`  in  1  marks the final word of the image.
- `InReady`  out  1  loader can accept a word this cycle.
- `WrEn`  out  1  instruction-RAM write strobe.
- `WrAddr`  out  IW  write address.
- `WrData`  out  DW  write data.
- `CpuHold`  out  1  hold the core in reset.
- `Done`  out  1  image loaded and padded.
- `Error`  out  1  image overflowed memory.
- `WordCount`  out  IW+1  words accepted in the current or last load.

## Operation
- States: IDLE, LOAD, FILL, DONE, ERR. An internal pointer `Ptr` is IW bits wide.
- Reset values: state=IDLE, `Ptr`=0, `WrEn`=0, `WrAddr`=0, `WrData`=0, `CpuHold`=1, `Done`=0, `Error`=0, `WordCount`=0.
- `InReady` is 1 iff state==LOAD. It is combinational from state only, never from `InValid`. Accept means `InValid & InReady`.
- IDLE/DONE/ERR with `Start`=1 → LOAD. On that transition: `Ptr`←0, `WordCount`←0, `Done`←0, `Error`←0, `CpuHold`←1.
- LOAD, accept:
  - `WrEn`←1, `WrAddr`←`Ptr`, `WrData`←`InData`, `Ptr`←`Ptr`+1 (wraps), `WordCount`←`WordCount`+1.
  - If `InLast`=1 and `Ptr`==2**IW−1 → DONE.
  - If `InLast`=1 and `Ptr`<2**IW−1 → FILL if `FILL_EN`, else DONE.
  - If `InLast`=0 and `Ptr`==2**IW−1 → ERR. That word is still written.
- LOAD, no accept: `WrEn`←0, stay in LOAD.
- FILL, every cycle:
  - `WrEn`←1, `WrAddr`←`Ptr`, `WrData`←`FILL_WORD`, `Ptr`←`Ptr`+1.
  - When `Ptr`==2**IW−1 → DONE.
  - `WordCount` does not change.
- DONE: `WrEn`←0, `Done`←1, `CpuHold`←0.
- ERR: `WrEn`←0, `Error`←1, `CpuHold` stays 1.
- `Start` in LOAD or FILL is ignored. `InValid` outside LOAD is ignored, with no write.
- `Reset` asserted mid-load returns to the reset values on the next edge. Words already written stay in the RAM; the loader does not clear them.

## Timing
- Write latency is 1 cycle: a word accepted at edge N appears on `WrEn`/`WrAddr`/`WrData` during cycle N+1.
- Throughput is 1 word per cycle while `InValid` is held high.
- `InReady` deasserts in the cycle after the `InLast` accept.
- `Done`/`CpuHold` change in the cycle after the final write strobe. The last write and core release are therefore never in the same cycle.
- FILL takes exactly 2**IW − (words loaded) cycles.
- A full-depth image (2**IW words, last word carries `InLast`) goes directly to DONE with no FILL cycles.
- An empty image is not possible: at least one word is always accepted.

## Structure
- Package `inst_loader_pkg` holds:
  - the state enum `ld_state_t` {IDLE, LOAD, FILL, DONE, ERR};
  - the default halt encoding constant used for `FILL_WORD`.
- No sub-module is required. The pointer/counter and FSM fit in one module.
- Integration: the `WrEn`/`WrAddr`/`WrData` outputs connect to the write port of `inst_ram`, a writable instruction memory owned separately.

## Test plan
- All tests use `IW`=4, `DW`=9.
- **Reset values:** assert `Reset` for 2 cycles → all outputs at their reset values; `InReady`=0; `CpuHold`=1.
- **Padded load:** `Start`, then 3 words 0x001, 0x002, 0x103 (`InLast` on the third), `FILL_EN`=1.
  - Writes: addr 0–2 with those values, then addr 3–15 = 0x1FF.
  - `Done` rises the cycle after the addr-15 write.
  - `WordCount`=3.
- **Full load:** 16 words, `InLast` on word 16 → no FILL writes, `Done`=1, `WordCount`=16, `Error`=0.
- **Overflow:** 17 words with no `InLast` → 16 writes, `Error`=1, `CpuHold`=1, `InReady`=0; word 17 is never accepted.
- **Backpressure/gaps:** `InValid` toggles 1,0,1,0; `Start` pulsed during LOAD → exactly one write per accepted word, addresses contiguous, `Start` ignored.
- **Reset mid-FILL, then reload:** `Reset` at `Ptr`=7 → IDLE next cycle. A subsequent `Start` reloads from addr 0 with `WordCount`=0.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package inst_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        FILL = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } ld_state_t;

    // Every bit of the halt encoding is one, whatever the word width.
    localparam logic HALT_BIT = 1'b1;

endpackage

// File: rtl/inst_loader.sv
// Streams a machine-code image into instruction RAM from address 0, optionally
// pads the remainder with a halt word, and holds the core in reset until done.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int              IW        = 10,
    parameter int              DW        = 9,
    parameter bit              FILL_EN   = 1'b1,
    parameter logic [DW-1:0]   FILL_WORD = {DW{HALT_BIT}}
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            InValid,
    input  logic [DW-1:0]   InData,
    input  logic            InLast,
    output logic            InReady,
    output logic            WrEn,
    output logic [IW-1:0]   WrAddr,
    output logic [DW-1:0]   WrData,
    output logic            CpuHold,
    output logic            Done,
    output logic            Error,
    output logic [IW:0]     WordCount
);

    localparam logic [IW-1:0] PTR_MAX = {IW{1'b1}};
    localparam logic [IW-1:0] PTR_ONE = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [IW:0]   CNT_ONE = {{IW{1'b0}}, 1'b1};

    ld_state_t       state_r;
    logic [IW-1:0]   ptr_r;
    logic            wr_en_r;
    logic [IW-1:0]   wr_addr_r;
    logic [DW-1:0]   wr_data_r;
    logic            cpu_hold_r;
    logic            done_r;
    logic            error_r;
    logic [IW:0]     word_count_r;
    logic            accept_s;

    // Ready depends on state alone so the upstream handshake has no comb loop.
    assign InReady  = (state_r == LOAD);
    assign accept_s = InValid & InReady;

    assign WrEn      = wr_en_r;
    assign WrAddr    = wr_addr_r;
    assign WrData    = wr_data_r;
    assign CpuHold   = cpu_hold_r;
    assign Done      = done_r;
    assign Error     = error_r;
    assign WordCount = word_count_r;

    // Loader FSM with pointer, word counter and registered write port.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r      <= IDLE;
            ptr_r        <= {IW{1'b0}};
            wr_en_r      <= 1'b0;
            wr_addr_r    <= {IW{1'b0}};
            wr_data_r    <= {DW{1'b0}};
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_count_r <= {(IW+1){1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    wr_en_r <= 1'b0;
                    if (Start) begin
                        state_r      <= LOAD;
                        ptr_r        <= {IW{1'b0}};
                        word_count_r <= {(IW+1){1'b0}};
                        done_r       <= 1'b0;
                        error_r      <= 1'b0;
                        cpu_hold_r   <= 1'b1;
                    end else if (state_r == DONE) begin
                        done_r     <= 1'b1;
                        cpu_hold_r <= 1'b0;
                    end else if (state_r == ERR) begin
                        error_r    <= 1'b1;
                        cpu_hold_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    if (accept_s) begin
                        wr_en_r      <= 1'b1;
                        wr_addr_r    <= ptr_r;
                        wr_data_r    <= InData;
                        ptr_r        <= ptr_r + PTR_ONE;
                        word_count_r <= word_count_r + CNT_ONE;
                        // The word at the top address is still written on overflow.
                        if (InLast) begin
                            if ((ptr_r == PTR_MAX) || !FILL_EN) begin
                                state_r <= DONE;
                            end else begin
                                state_r <= FILL;
                            end
                        end else if (ptr_r == PTR_MAX) begin
                            state_r <= ERR;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
                FILL: begin
                    wr_en_r   <= 1'b1;
                    wr_addr_r <= ptr_r;
                    wr_data_r <= FILL_WORD;
                    ptr_r     <= ptr_r + PTR_ONE;
                    if (ptr_r == PTR_MAX) begin
                        state_r <= DONE;
                    end else begin
                        state_r <= FILL;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    wr_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes are queued as words are
// driven and matched against the RAM write port on the falling edge.
module tb_inst_loader;

    localparam int IW = 4;
    localparam int DW = 9;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] HALT = 9'h1FF;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic            InValid;
    logic [DW-1:0]   InData;
    logic            InLast;
    logic            InReady;
    logic            WrEn;
    logic [IW-1:0]   WrAddr;
    logic [DW-1:0]   WrData;
    logic            CpuHold;
    logic            Done;
    logic            Error;
    logic [IW:0]     WordCount;

    int n_cmp = 0;
    int n_err = 0;
    int exp_ptr = 0;
    logic [IW+DW-1:0] exp_q[$];

    inst_loader #(
        .IW(IW), .DW(DW), .FILL_EN(1'b1), .FILL_WORD(HALT)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .InValid(InValid),
        .InData(InData), .InLast(InLast), .InReady(InReady), .WrEn(WrEn),
        .WrAddr(WrAddr), .WrData(WrData), .CpuHold(CpuHold), .Done(Done),
        .Error(Error), .WordCount(WordCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge Clk) begin
        if (WrEn !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", {28'd0, WrAddr}, 32'hFFFF_FFFF);
            end else begin
                logic [IW+DW-1:0] e;
                e = exp_q.pop_front();
                check_eq("wr_addr", {28'd0, WrAddr}, {28'd0, e[IW+DW-1:DW]});
                check_eq("wr_data", {23'd0, WrData}, {23'd0, e[DW-1:0]});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last);
        InValid = 1'b1;
        InData  = d;
        InLast  = last;
        exp_q.push_back({exp_ptr[IW-1:0], d});
        exp_ptr = (exp_ptr + 1) % DEPTH;
        tick();
        InValid = 1'b0;
        InLast  = 1'b0;
    endtask

    task automatic push_fill(input int from, input int to);
        for (int a = from; a <= to; a++) begin
            logic [IW-1:0] aa;
            aa = a[IW-1:0];
            exp_q.push_back({aa, HALT});
        end
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (Done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq("done_within_budget", {31'd0, Done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = '0; InLast = 1'b0;
        tick();
        tick();
        check_eq("rst_wren",   {31'd0, WrEn},    32'd0);
        check_eq("rst_waddr",  {28'd0, WrAddr},  32'd0);
        check_eq("rst_wdata",  {23'd0, WrData},  32'd0);
        check_eq("rst_hold",   {31'd0, CpuHold}, 32'd1);
        check_eq("rst_done",   {31'd0, Done},    32'd0);
        check_eq("rst_error",  {31'd0, Error},   32'd0);
        check_eq("rst_count",  {27'd0, WordCount}, 32'd0);
        check_eq("rst_ready",  {31'd0, InReady}, 32'd0);
        Reset = 1'b0;
        tick();
        check_eq("idle_ready", {31'd0, InReady}, 32'd0);

        // Padded load: 3 words then halt fill to the top address.
        start_load();
        check_eq("load_ready", {31'd0, InReady}, 32'd1);
        send_word(9'h001, 1'b0);
        send_word(9'h002, 1'b0);
        send_word(9'h103, 1'b1);
        push_fill(3, 15);
        check_eq("pad_ready_drop", {31'd0, InReady}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        tick();
        check_eq("pad_last_wr_en", {31'd0, WrEn},   32'd1);
        check_eq("pad_last_addr",  {28'd0, WrAddr}, 32'd15);
        check_eq("pad_done_late",  {31'd0, Done},   32'd0);
        check_eq("pad_hold_late",  {31'd0, CpuHold}, 32'd1);
        tick();
        check_eq("pad_done",   {31'd0, Done},    32'd1);
        check_eq("pad_hold",   {31'd0, CpuHold}, 32'd0);
        check_eq("pad_count",  {27'd0, WordCount}, 32'd3);
        check_eq("pad_sb_empty", exp_q.size(), 32'd0);

        // Full-depth load: no fill cycles.
        start_load();
        check_eq("full_done_clr", {31'd0, Done}, 32'd0);
        for (int i = 0; i < DEPTH; i++) send_word(9'(i * 7 + 3), (i == DEPTH - 1));
        check_eq("full_done_late", {31'd0, Done}, 32'd0);
        tick();
        check_eq("full_done",  {31'd0, Done},  32'd1);
        check_eq("full_error", {31'd0, Error}, 32'd0);
        check_eq("full_count", {27'd0, WordCount}, 32'd16);
        tick();
        tick();
        check_eq("full_sb_empty", exp_q.size(), 32'd0);

        // Overflow: 17 words with no last marker.
        start_load();
        for (int i = 0; i < DEPTH; i++) send_word(9'(i + 9'h040), 1'b0);
        InValid = 1'b1; InData = 9'h0AA; InLast = 1'b0;
        check_eq("ovf_ready_drop", {31'd0, InReady}, 32'd0);
        tick();
        check_eq("ovf_error", {31'd0, Error},   32'd1);
        check_eq("ovf_hold",  {31'd0, CpuHold}, 32'd1);
        check_eq("ovf_done",  {31'd0, Done},    32'd0);
        check_eq("ovf_ready", {31'd0, InReady}, 32'd0);
        tick();
        tick();
        check_eq("ovf_count", {27'd0, WordCount}, 32'd16);
        InValid = 1'b0;
        check_eq("ovf_sb_empty", exp_q.size(), 32'd0);

        // Backpressure with gaps and Start pulses during LOAD.
        start_load();
        check_eq("bp_error_clr", {31'd0, Error}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            send_word(9'(9'h150 + i), (i == 3));
            if (i < 3) begin
                Start = 1'b1;
                tick();
                Start = 1'b0;
            end
        end
        push_fill(4, 15);
        wait_done(40);
        check_eq("bp_count", {27'd0, WordCount}, 32'd4);
        check_eq("bp_sb_empty", exp_q.size(), 32'd0);

        // Reset while filling at pointer 7, then reload from address 0.
        start_load();
        send_word(9'h055, 1'b1);
        push_fill(1, 6);
        for (int i = 0; i < 6; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("mid_rst_wren",  {31'd0, WrEn},    32'd0);
        check_eq("mid_rst_hold",  {31'd0, CpuHold}, 32'd1);
        check_eq("mid_rst_done",  {31'd0, Done},    32'd0);
        check_eq("mid_rst_count", {27'd0, WordCount}, 32'd0);
        check_eq("mid_rst_addr",  {28'd0, WrAddr},  32'd0);
        check_eq("mid_rst_sb_empty", exp_q.size(), 32'd0);
        tick();
        check_eq("mid_rst_idle", {31'd0, InReady}, 32'd0);
        start_load();
        check_eq("reload_count", {27'd0, WordCount}, 32'd0);
        check_eq("reload_ready", {31'd0, InReady},   32'd1);
        send_word(9'h0C1, 1'b0);
        send_word(9'h0C2, 1'b1);
        push_fill(2, 15);
        wait_done(40);
        check_eq("reload_wc", {27'd0, WordCount}, 32'd2);
        tick();
        check_eq("reload_sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
